// File: rtl/sprite_compositor.sv
// Composites N_SPR ROM-backed sprite layers over a background colour, with
// frame-synchronous position commits, per-layer blink and an idle blanker.
module sprite_compositor #(
  parameter int          N_SPR        = 4,
  parameter int          CW           = 10,
  parameter int          SPR_W        = 64,
  parameter int          SPR_H        = 64,
  parameter logic [23:0] KEY_RGB      = 24'hFF00FF,
  parameter int          BLINK_FRAMES = 30,
  parameter int          IDLE_FRAMES  = 1800,
  localparam int         XW           = $clog2(SPR_W),
  localparam int         YW           = $clog2(SPR_H),
  localparam int         AW           = XW + YW
) (
  input  logic                FPGA_Clock,
  input  logic                FPGA_Reset_N,
  input  logic                pix_ce,
  input  logic [CW-1:0]       h_count,
  input  logic [CW-1:0]       v_count,
  output logic [N_SPR*AW-1:0] rom_addr,
  input  logic [N_SPR*24-1:0] rom_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_layer,
  input  logic [CW-1:0]       cfg_x,
  input  logic [CW-1:0]       cfg_y,
  input  logic                cfg_en,
  input  logic                cfg_blink,
  input  logic [23:0]         bg_rgb,
  input  logic                activity,
  output logic [23:0]         RGB,
  output logic                visible,
  output logic                LED_Sleep
);

  localparam int FCW = $clog2(BLINK_FRAMES + 1);
  localparam int ICW = $clog2(IDLE_FRAMES + 1);

  logic                frame_start;
  logic                cfg_xfer;
  logic                commit;
  logic                sleeping;

  logic                pend_valid_reg;
  logic [2:0]          pend_layer_reg;
  logic [CW-1:0]       pend_x_reg;
  logic [CW-1:0]       pend_y_reg;
  logic                pend_en_reg;
  logic                pend_blink_reg;

  logic [FCW-1:0]      frame_cnt_reg;
  logic                blink_phase_reg;
  logic [ICW-1:0]      idle_cnt_reg;

  logic [N_SPR-1:0]    hit_next;
  logic [N_SPR-1:0]    hit0_reg;
  logic [N_SPR-1:0]    hit1_reg;
  logic [N_SPR-1:0]    opaque;
  logic [N_SPR*AW-1:0] addr_next;
  logic [N_SPR*AW-1:0] rom_addr_reg;
  logic [23:0]         bg0_reg;
  logic [23:0]         bg1_reg;
  logic [23:0]         rgb_next;
  logic [23:0]         rgb_reg;
  logic                visible_reg;

  assign frame_start = pix_ce && (h_count == '0) && (v_count == '0);
  assign cfg_ready   = !pend_valid_reg;
  assign cfg_xfer    = cfg_valid && cfg_ready;
  // Only a slot that was already full before this frame_start commits.
  assign commit      = frame_start && pend_valid_reg;
  assign sleeping    = (idle_cnt_reg == ICW'(IDLE_FRAMES));

  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_N) begin
    if (!FPGA_Reset_N) begin
      pend_valid_reg <= 1'b0;
      pend_layer_reg <= '0;
      pend_x_reg     <= '0;
      pend_y_reg     <= '0;
      pend_en_reg    <= 1'b0;
      pend_blink_reg <= 1'b0;
    end else if (cfg_xfer) begin
      pend_valid_reg <= 1'b1;
      pend_layer_reg <= cfg_layer;
      pend_x_reg     <= cfg_x;
      pend_y_reg     <= cfg_y;
      pend_en_reg    <= cfg_en;
      pend_blink_reg <= cfg_blink;
    end else if (commit) begin
      pend_valid_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < N_SPR; gi++) begin : g_layer
    logic [CW-1:0] x_reg;
    logic [CW-1:0] y_reg;
    logic          en_reg;
    logic          blink_reg;
    logic [CW:0]   dx;
    logic [CW:0]   dy;

    always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_N) begin
      if (!FPGA_Reset_N) begin
        x_reg     <= '0;
        y_reg     <= '0;
        en_reg    <= 1'b0;
        blink_reg <= 1'b0;
      end else if (commit && (pend_layer_reg == 3'(gi))) begin
        x_reg     <= pend_x_reg;
        y_reg     <= pend_y_reg;
        en_reg    <= pend_en_reg;
        blink_reg <= pend_blink_reg;
      end
    end

    // One extra bit keeps an underflow (h < X) far above the sprite size.
    assign dx = {1'b0, h_count} - {1'b0, x_reg};
    assign dy = {1'b0, v_count} - {1'b0, y_reg};
    assign hit_next[gi] = en_reg && (dx < (CW+1)'(SPR_W)) && (dy < (CW+1)'(SPR_H));
    assign addr_next[gi*AW +: AW] = {dy[YW-1:0], dx[XW-1:0]};
    assign opaque[gi] = hit1_reg[gi] && (rom_data[gi*24 +: 24] != KEY_RGB)
                        && !(blink_reg && blink_phase_reg);
  end

  // Lowest-numbered opaque layer wins.
  always_comb begin
    rgb_next = bg1_reg;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) rgb_next = rom_data[i*24 +: 24];
    end
  end

  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_N) begin
    if (!FPGA_Reset_N) begin
      rom_addr_reg <= '0;
      hit0_reg     <= '0;
      bg0_reg      <= '0;
      hit1_reg     <= '0;
      bg1_reg      <= '0;
      rgb_reg      <= '0;
      visible_reg  <= 1'b0;
    end else if (pix_ce) begin
      rom_addr_reg <= addr_next;
      hit0_reg     <= hit_next;
      bg0_reg      <= bg_rgb;
      hit1_reg     <= hit0_reg;
      bg1_reg      <= bg0_reg;
      rgb_reg      <= sleeping ? 24'h000000 : rgb_next;
      visible_reg  <= !sleeping && (|opaque);
    end
  end

  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_N) begin
    if (!FPGA_Reset_N) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt_reg == FCW'(BLINK_FRAMES - 1)) begin
        frame_cnt_reg   <= '0;
        blink_phase_reg <= !blink_phase_reg;
      end else begin
        frame_cnt_reg   <= frame_cnt_reg + FCW'(1);
      end
    end
  end

  // A wake event outranks a simultaneous frame_start increment.
  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_N) begin
    if (!FPGA_Reset_N) begin
      idle_cnt_reg <= '0;
    end else if (activity || cfg_xfer) begin
      idle_cnt_reg <= '0;
    end else if (frame_start && !sleeping) begin
      idle_cnt_reg <= idle_cnt_reg + ICW'(1);
    end
  end

  assign rom_addr  = rom_addr_reg;
  assign RGB       = rgb_reg;
  assign visible   = visible_reg;
  assign LED_Sleep = sleeping;

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised scoreboard bench for sprite_compositor: a driver predicts each
// output pixel from sprite geometry rules, a monitor compares on every pix_ce.
module tb_sprite_compositor;

  localparam int          N       = 4;
  localparam int          CW      = 10;
  localparam int          SW      = 64;
  localparam int          SH      = 64;
  localparam int          AW      = 12;
  localparam logic [23:0] KEY     = 24'hFF00FF;
  localparam int          BLINK_F = 2;
  localparam int          IDLE_F  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pix_ce;
  logic [CW-1:0]     h_count, v_count;
  logic [N*AW-1:0]   rom_addr;
  logic [N*24-1:0]   rom_data;
  logic              cfg_valid, cfg_ready;
  logic [2:0]        cfg_layer;
  logic [CW-1:0]     cfg_x, cfg_y;
  logic              cfg_en, cfg_blink;
  logic [23:0]       bg_rgb;
  logic              activity;
  logic [23:0]       RGB;
  logic              visible, LED_Sleep;

  sprite_compositor #(
    .N_SPR(N), .CW(CW), .SPR_W(SW), .SPR_H(SH), .KEY_RGB(KEY),
    .BLINK_FRAMES(BLINK_F), .IDLE_FRAMES(IDLE_F)
  ) dut (
    .FPGA_Clock(clk), .FPGA_Reset_N(rst_n), .pix_ce(pix_ce),
    .h_count(h_count), .v_count(v_count), .rom_addr(rom_addr), .rom_data(rom_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
    .bg_rgb(bg_rgb), .activity(activity), .RGB(RGB), .visible(visible),
    .LED_Sleep(LED_Sleep)
  );

  always #5 clk = ~clk;

  // Sprite ROMs: synchronous read advancing on pix_ce.
  logic [23:0] rom_mem [N][SW*SH];
  always @(posedge clk) begin
    if (pix_ce) begin
      for (int i = 0; i < N; i++) rom_data[i*24 +: 24] <= rom_mem[i][rom_addr[i*AW +: AW]];
    end
  end

  typedef struct { logic [2:0] layer; int x; int y; bit en; bit blink; } cfg_t;
  typedef struct { logic [23:0] bg; logic [N-1:0] hit; logic [N*24-1:0] pix; } pix_t;
  typedef struct { logic [23:0] rgb; bit vis; } exp_t;
  typedef struct { logic [N-1:0] hit; logic [N*AW-1:0] addr; } aexp_t;

  cfg_t  cfg_q[$];
  pix_t  pipe[$];
  exp_t  sq[$];
  aexp_t aq[$];

  int   m_x[N], m_y[N];
  bit   m_en[N], m_blink[N];
  bit   m_ready, m_phase;
  cfg_t m_pend;
  int   m_fc, m_idle;

  int n_tests = 0;
  int n_fail  = 0;

  int dh[8] = '{5, 63, 64, 99, 100, 163, 164, 1010};
  int dv[8] = '{45, 1, 1, 60, 60, 60, 60, 41};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  task automatic model_reset();
    pix_t b;
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_en[i] = 0; m_blink[i] = 0;
    end
    m_ready = 1; m_phase = 0; m_fc = 0; m_idle = 0;
    pipe.delete(); sq.delete(); aq.delete(); cfg_q.delete();
    b.bg = '0; b.hit = '0; b.pix = '0;
    pipe.push_back(b);
    pipe.push_back(b);
  endtask

  task automatic push_cfg(input int layer, input int x, input int y, input bit en, input bit blink);
    cfg_t c;
    c.layer = 3'(layer); c.x = x; c.y = y; c.en = en; c.blink = blink;
    cfg_q.push_back(c);
  endtask

  // One clock: drive inputs, predict, then advance the reference state.
  task automatic step(input bit pce, input int h, input int v, input bit act);
    pix_t  p, d;
    exp_t  e;
    aexp_t a;
    bit    fs, xfer, sl;
    int    dx, dy, li;
    @(negedge clk);
    pix_ce = pce; h_count = CW'(h); v_count = CW'(v); activity = act;
    bg_rgb = 24'($urandom);
    if (cfg_q.size() > 0) begin
      cfg_valid = 1'b1; cfg_layer = cfg_q[0].layer;
      cfg_x = CW'(cfg_q[0].x); cfg_y = CW'(cfg_q[0].y);
      cfg_en = cfg_q[0].en; cfg_blink = cfg_q[0].blink;
    end else begin
      cfg_valid = 1'b0; cfg_layer = 3'($urandom);
      cfg_x = CW'($urandom); cfg_y = CW'($urandom);
      cfg_en = 1'($urandom); cfg_blink = 1'($urandom);
    end
    fs   = pce && h == 0 && v == 0;
    xfer = cfg_valid && m_ready;
    sl   = (m_idle == IDLE_F);
    check("cfg_ready", 64'(cfg_ready), 64'(m_ready));
    check("LED_Sleep", 64'(LED_Sleep), 64'(sl));
    if (pce) begin
      p.bg = bg_rgb; p.hit = '0; p.pix = '0; a.hit = '0; a.addr = '0;
      for (int i = 0; i < N; i++) begin
        dx = h - m_x[i];
        dy = v - m_y[i];
        if (m_en[i] && dx >= 0 && dx < SW && dy >= 0 && dy < SH) begin
          p.hit[i] = 1'b1;
          a.hit[i] = 1'b1;
          a.addr[i*AW +: AW] = AW'(dy * SW + dx);
          p.pix[i*24 +: 24]  = rom_mem[i][dy * SW + dx];
        end
      end
      pipe.push_back(p);
      aq.push_back(a);
      d = pipe.pop_front();
      e.rgb = d.bg; e.vis = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (d.hit[i] && d.pix[i*24 +: 24] != KEY && !(m_blink[i] && m_phase)) begin
          e.rgb = d.pix[i*24 +: 24];
          e.vis = 1;
        end
      end
      if (sl) begin e.rgb = '0; e.vis = 0; end
      sq.push_back(e);
    end
    if (xfer) begin
      m_pend  = cfg_q.pop_front();
      m_ready = 0;
    end else if (fs && !m_ready) begin
      li = int'(m_pend.layer);
      if (li < N) begin
        m_x[li] = m_pend.x; m_y[li] = m_pend.y;
        m_en[li] = m_pend.en; m_blink[li] = m_pend.blink;
      end
      m_ready = 1;
    end
    if (act || xfer) m_idle = 0;
    else if (fs && m_idle < IDLE_F) m_idle++;
    if (fs) begin
      if (m_fc == BLINK_F - 1) begin m_fc = 0; m_phase = !m_phase; end
      else m_fc++;
    end
  endtask

  // One synthetic frame: the (0,0) pixel, then pixels clustered on sprite edges.
  task automatic frame(input int npix, input int act_pct);
    int h, v, l, k;
    step(1'b1, 0, 0, pct(act_pct));
    for (int n = 0; n < npix; n++) begin
      while ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) step(1'b0, 0, 0, pct(act_pct));
        else step(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), pct(act_pct));
      end
      k = int'($urandom_range(0, 9));
      if (k == 0) begin
        l = int'($urandom_range(0, 7)); h = dh[l]; v = dv[l];
      end else if (k == 1) begin
        h = int'($urandom_range(1, 1023)); v = int'($urandom_range(0, 1023));
      end else begin
        l = int'($urandom_range(0, N - 1));
        h = (m_x[l] + int'($urandom_range(0, SW + 3)) - 2 + 1024) % 1024;
        v = (m_y[l] + int'($urandom_range(0, SH + 3)) - 2 + 1024) % 1024;
      end
      step(1'b1, h, v, pct(act_pct));
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_RGB"}, 64'(RGB), 64'(0));
    check({tag, "_visible"}, 64'(visible), 64'(0));
    check({tag, "_LED_Sleep"}, 64'(LED_Sleep), 64'(0));
    check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'(1));
    check({tag, "_rom_addr_zero"}, 64'(rom_addr == '0), 64'(1));
  endtask

  // Monitor: one output pixel (and its ROM address set) per pix_ce edge.
  initial begin
    bit    pce_s, rst_s;
    exp_t  e;
    aexp_t a;
    forever begin
      @(posedge clk);
      pce_s = pix_ce;
      rst_s = rst_n;
      #1;
      if (rst_s && pce_s) begin
        if (sq.size() == 0 || aq.size() == 0) begin
          check("scoreboard_underflow", 64'(1), 64'(0));
        end else begin
          e = sq.pop_front();
          a = aq.pop_front();
          check("RGB", 64'(RGB), 64'(e.rgb));
          check("visible", 64'(visible), 64'(e.vis));
          for (int i = 0; i < N; i++) begin
            if (a.hit[i]) check("rom_addr", 64'(rom_addr[i*AW +: AW]), 64'(a.addr[i*AW +: AW]));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; pix_ce = 1'b0; h_count = '0; v_count = '0;
    cfg_valid = 1'b0; cfg_layer = '0; cfg_x = '0; cfg_y = '0;
    cfg_en = 1'b0; cfg_blink = 1'b0; bg_rgb = '0; activity = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < SW * SH; j++) begin
        rom_mem[i][j] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
      end
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    // All layers disabled: background only.
    repeat (2) frame(30, 5);

    push_cfg(0, 100, 50, 1, 0);
    push_cfg(1, 120, 70, 1, 0);
    push_cfg(2, 1000, 40, 1, 0);
    push_cfg(3, 0, 0, 1, 1);
    push_cfg(5, 7, 7, 1, 1);
    repeat (8) frame(40, 5);

    push_cfg(0, 200, 200, 1, 0);
    push_cfg(1, 230, 220, 1, 1);
    repeat (6) frame(40, 5);

    repeat (8) begin
      push_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 400)),
               int'($urandom_range(0, 400)), $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)));
      frame(40, 5);
    end

    // Quiet frames put the block to sleep; a busy frame wakes it.
    repeat (5) frame(30, 0);
    frame(30, 30);
    repeat (2) frame(30, 5);

    // Reset in the middle of a line with a write still pending.
    push_cfg(0, 10, 10, 1, 0);
    repeat (10) step(1'b1, int'($urandom_range(1, 300)), int'($urandom_range(1, 300)), 1'b0);
    @(negedge clk);
    pix_ce = 1'b0; cfg_valid = 1'b0; activity = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_checks("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) frame(30, 5);

    repeat (3) step(1'b0, 5, 5, 1'b0);
    check("scoreboard_drained", 64'(sq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
